clint: RTL and testbench

Core-local interruptor for the Noname core: a memory-mapped timer and software-interrupt block on a Wishbone-classic slave port. It generates the machine timer-interrupt and software-interrupt request lines consumed by the write-back stage's mip/mcause logic (`xint_mtip_i`, `xint_msip_i`). The block contains a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and a 1-bit `msip` register, and it compares `mtime` against `mtimecmp` every cycle.

---
 rtl/clint.sv | 125 ++++++++++++
 tb/tb_clint.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint.sv
// rtl/clint.sv - core-local interruptor: mtime/mtimecmp/msip behind a Wishbone-classic slave
// Optional prescaler selected by CLINT_PRESCALE_EN (TICK_DIV cycles per mtime tick).
module clint #(
  parameter int TICK_DIV = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        xint_mtip_o,
  output logic        xint_msip_o
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state_q, state_d;
  logic [63:0] mtime_q, mtime_d, mtime_inc;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        tick;
  logic        take, wr, mapped;
  logic        hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi;
  logic [15:0] word_addr;
  logic [31:0] wmask, rdata;

  if (TICK_DIV < 1 || TICK_DIV > 65535) begin : g_tick_div_range
    $error("clint: TICK_DIV must be in 1..65535");
  end

`ifdef CLINT_PRESCALE_EN
  logic [15:0] presc_q;

  assign tick = (presc_q == 16'(TICK_DIV - 1));

  // Free-running divider; mtime writes deliberately leave its phase alone.
  always_ff @(posedge clk_i) begin
    if (rst_i)     presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + 16'd1;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    word_addr   = {wbs_addr_i[15:2], 2'b00};
    hit_msip    = (word_addr == 16'h0000);
    hit_cmp_lo  = (word_addr == 16'h4000);
    hit_cmp_hi  = (word_addr == 16'h4004);
    hit_time_lo = (word_addr == 16'hBFF8);
    hit_time_hi = (word_addr == 16'hBFFC);
    mapped      = hit_msip | hit_cmp_lo | hit_cmp_hi | hit_time_lo | hit_time_hi;
    take        = (state_q == IDLE) && wbs_cyc_i && wbs_stb_i;
    wr          = take && wbs_we_i && mapped;
    wmask       = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Unwritten bytes of mtime keep the incremented value, written bytes override it.
  always_comb begin
    mtime_inc  = mtime_q + {63'd0, tick};
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr && hit_time_lo)
      mtime_d[31:0] = (mtime_inc[31:0] & ~wmask) | (wbs_dat_i & wmask);
    if (wr && hit_time_hi)
      mtime_d[63:32] = (mtime_inc[63:32] & ~wmask) | (wbs_dat_i & wmask);
    if (wr && hit_cmp_lo)
      mtimecmp_d[31:0] = (mtimecmp_q[31:0] & ~wmask) | (wbs_dat_i & wmask);
    if (wr && hit_cmp_hi)
      mtimecmp_d[63:32] = (mtimecmp_q[63:32] & ~wmask) | (wbs_dat_i & wmask);
    if (wr && hit_msip && wbs_sel_i[0])
      msip_d = wbs_dat_i[0];
  end

  always_comb begin
    rdata = '0;
    if (hit_msip)    rdata = {31'd0, msip_q};
    if (hit_cmp_lo)  rdata = mtimecmp_q[31:0];
    if (hit_cmp_hi)  rdata = mtimecmp_q[63:32];
    if (hit_time_lo) rdata = mtime_q[31:0];
    if (hit_time_hi) rdata = mtime_q[63:32];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      xint_mtip_o <= 1'b0;
      wbs_ack_o   <= 1'b0;
      wbs_err_o   <= 1'b0;
      wbs_dat_o   <= '0;
    end else begin
      state_q     <= state_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      xint_mtip_o <= (mtime_q >= mtimecmp_q);
      wbs_ack_o   <= take && mapped;
      wbs_err_o   <= take && !mapped;
      wbs_dat_o   <= take ? rdata : 32'd0;
    end
  end

  assign xint_msip_o = msip_q;

endmodule

// File: tb/tb_clint.sv
// tb/tb_clint.sv - randomized self-checking bench for clint against a tick-count reference model
module tb_clint;

`ifdef CLINT_PRESCALE_EN
  localparam int DIV = 10;
`else
  localparam int DIV = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] wbs_addr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic [3:0]  wbs_sel_i = '0;
  logic        wbs_we_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o, xint_mtip_o, xint_msip_o;

  clint #(.TICK_DIV(10)) dut (
    .clk_i(clk), .rst_i(rst_i), .wbs_addr_i(wbs_addr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_sel_i(wbs_sel_i), .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .xint_mtip_o(xint_mtip_o), .xint_msip_o(xint_msip_o)
  );

  always #5 clk = ~clk;

  longint unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mtime is a base value plus the number of ticks since the base edge.
  logic [63:0]     m_base_val, m_cmp;
  longint unsigned m_base_edge, m_rst_edge;
  logic            m_msip;

  function automatic longint unsigned n_ticks(input longint unsigned a, input longint unsigned b);
    return (b - m_rst_edge) / DIV - (a - m_rst_edge) / DIV;
  endfunction

  function automatic logic [63:0] mtime_at(input longint unsigned e);
    return m_base_val + n_ticks(m_base_edge, e);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel, input int half);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[half * 32 + i * 8 +: 8] = wd[i * 8 +: 8];
    return r;
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_rst_edge  = edge_cnt;
    m_base_edge = edge_cnt;
    m_base_val  = '0;
    m_cmp       = '1;
    m_msip      = 1'b0;
    rst_i = 1'b0;
  endtask

  // One bus transfer; returns DUT observations and model expectations side by side.
  task automatic bus(input logic we, input logic [15:0] addr, input logic [31:0] wd, input logic [3:0] sel,
                     output logic [31:0] rd, output logic ack, output logic err,
                     output logic mtip0, output logic msip0, output logic mtip1,
                     output logic [31:0] x_rd, output logic x_ack, output logic x_err,
                     output logic x_mtip0, output logic x_msip0, output logic x_mtip1);
    longint unsigned e;
    logic [63:0] pre;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_addr_i = addr; wbs_dat_i = wd; wbs_sel_i = sel;
    @(posedge clk);
    #1;
    e = edge_cnt;
    rd = wbs_dat_o; ack = wbs_ack_o; err = wbs_err_o;
    mtip0 = xint_mtip_o; msip0 = xint_msip_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    pre = mtime_at(e - 1);
    x_mtip0 = (pre >= m_cmp);
    x_ack = 1'b1; x_err = 1'b0; x_rd = '0;
    case (addr & 16'hFFFC)
      16'h0000: begin
        x_rd = {31'd0, m_msip};
        if (we && sel[0]) m_msip = wd[0];
      end
      16'h4000: begin x_rd = m_cmp[31:0];  if (we) m_cmp = merge(m_cmp, wd, sel, 0); end
      16'h4004: begin x_rd = m_cmp[63:32]; if (we) m_cmp = merge(m_cmp, wd, sel, 1); end
      16'hBFF8, 16'hBFFC: begin
        x_rd = addr[2] ? pre[63:32] : pre[31:0];
        if (we) begin
          m_base_val  = merge(pre + n_ticks(e - 1, e), wd, sel, addr[2] ? 1 : 0);
          m_base_edge = e;
        end
      end
      default: begin x_ack = 1'b0; x_err = 1'b1; end
    endcase
    x_msip0 = m_msip;
    @(posedge clk);
    #1;
    mtip1 = xint_mtip_o;
    x_mtip1 = (mtime_at(e) >= m_cmp);
  endtask

  logic [31:0] rd, x_rd;
  logic ack, err, mt0, ms0, mt1, x_ack, x_err, x_mt0, x_ms0, x_mt1;

  task automatic test_reset();
    do_reset();
    n_cmp += 5;
    if (wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", wbs_ack_o); end
    if (wbs_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", wbs_err_o); end
    if (wbs_dat_o !== 32'd0) begin n_bad++; $display("FAIL reset_dat: got %h want 0", wbs_dat_o); end
    if (xint_mtip_o !== 1'b0) begin n_bad++; $display("FAIL reset_mtip: got %b want 0", xint_mtip_o); end
    if (xint_msip_o !== 1'b0) begin n_bad++; $display("FAIL reset_msip: got %b want 0", xint_msip_o); end
    bus(0, 16'hBFF8, 0, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    n_cmp += 2;
    if (ack !== 1'b1) begin n_bad++; $display("FAIL reset_mtime_ack: got %b want 1", ack); end
    if (rd !== x_rd) begin n_bad++; $display("FAIL reset_mtime: got %h want %h", rd, x_rd); end
    bus(0, 16'h4004, 0, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    n_cmp += 2;
    if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_cmp_hi: got %h want ffffffff", rd); end
    if (mt1 !== 1'b0) begin n_bad++; $display("FAIL reset_mtip_after: got %b want 0", mt1); end
  endtask

  task automatic test_timer();
    longint unsigned exp_e, got_e;
    bit seen;
    do_reset();
    bus(1, 16'h4004, 32'h0, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    bus(1, 16'h4000, 32'h40, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    n_cmp++;
    if (mt1 !== 1'b0) begin n_bad++; $display("FAIL timer_early: got %b want 0", mt1); end
    exp_e = edge_cnt;
    while (mtime_at(exp_e) < 64'h40) exp_e++;
    exp_e++;
    seen = 0;
    got_e = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (xint_mtip_o === 1'b1) begin seen = 1; got_e = edge_cnt; end
    end
    n_cmp++;
    if (!seen || got_e != exp_e) begin
      n_bad++; $display("FAIL timer_rise_edge: got %0d want %0d (seen=%0d)", got_e, exp_e, seen);
    end
    bus(1, 16'h4000, 32'hFFFF_FFFF, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    n_cmp += 2;
    if (mt0 !== 1'b1) begin n_bad++; $display("FAIL timer_hold_at_ack: got %b want 1", mt0); end
    if (mt1 !== 1'b0) begin n_bad++; $display("FAIL timer_fall: got %b want 0", mt1); end
  endtask

  task automatic test_msip();
    bus(1, 16'h0000, 32'h1, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    n_cmp++;
    if (ms0 !== 1'b1) begin n_bad++; $display("FAIL msip_set: got %b want 1", ms0); end
    bus(0, 16'h0000, 32'h0, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    n_cmp++;
    if (rd !== 32'h1) begin n_bad++; $display("FAIL msip_read: got %h want 00000001", rd); end
    bus(1, 16'h0000, 32'h0, 4'h0, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    n_cmp += 2;
    if (ack !== 1'b1) begin n_bad++; $display("FAIL sel0_ack: got %b want 1", ack); end
    if (ms0 !== 1'b1) begin n_bad++; $display("FAIL sel0_nochange: got %b want 1", ms0); end
    bus(1, 16'h0000, 32'hFFFF_FFFE, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    n_cmp++;
    if (ms0 !== 1'b0) begin n_bad++; $display("FAIL msip_clear: got %b want 0", ms0); end
  endtask

  task automatic test_bytes();
    bus(1, 16'h4000, 32'hFFFF_FFFF, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    bus(1, 16'h4000, 32'hAABB_CCDD, 4'b0101, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    bus(0, 16'h4000, 32'h0, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    n_cmp++;
    if (rd !== 32'hFFBB_FFDD) begin n_bad++; $display("FAIL byte_enable: got %h want ffbbffdd", rd); end
    bus(0, 16'h1000, 32'h0, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    n_cmp += 3;
    if (err !== 1'b1) begin n_bad++; $display("FAIL unmapped_err: got %b want 1", err); end
    if (ack !== 1'b0) begin n_bad++; $display("FAIL unmapped_ack: got %b want 0", ack); end
    if (rd !== 32'd0) begin n_bad++; $display("FAIL unmapped_data: got %h want 0", rd); end
  endtask

  task automatic test_wrap();
    bus(1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    bus(1, 16'hBFF8, 32'hFFFF_FFFE, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    bus(0, 16'hBFF8, 32'h0, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    n_cmp++;
    if (rd !== x_rd) begin n_bad++; $display("FAIL wrap_lo: got %h want %h", rd, x_rd); end
    bus(0, 16'hBFFC, 32'h0, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    n_cmp++;
    if (rd !== x_rd) begin n_bad++; $display("FAIL wrap_hi: got %h want %h", rd, x_rd); end
    bus(1, 16'hBFF8, 32'h0000_00FF, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    bus(1, 16'hBFF8, 32'h1234_5655, 4'b0001, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    bus(0, 16'hBFF8, 32'h0, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    n_cmp++;
    if (rd !== x_rd) begin n_bad++; $display("FAIL collision_lo: got %h want %h", rd, x_rd); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_addr_i = 16'h0000; wbs_sel_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      pat[i] = wbs_ack_o;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    n_cmp++;
    if (pat !== 4'b0101) begin n_bad++; $display("FAIL back_to_back_ack: got %b want 0101", pat); end
  endtask

  task automatic test_rst_mid();
    bus(1, 16'h0000, 32'h1, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_addr_i = 16'h4000;
    wbs_dat_i = 32'h1234_5678; wbs_sel_i = 4'hF; rst_i = 1'b1;
    @(posedge clk);
    #1;
    n_cmp += 3;
    if (wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ack: got %b want 0", wbs_ack_o); end
    if (wbs_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_err: got %b want 0", wbs_err_o); end
    if (xint_msip_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_msip: got %b want 0", xint_msip_o); end
    do_reset();
    bus(0, 16'h4000, 32'h0, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    n_cmp++;
    if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_mid_cmp: got %h want ffffffff", rd); end
    bus(0, 16'hBFF8, 32'h0, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    n_cmp++;
    if (rd !== x_rd) begin n_bad++; $display("FAIL rst_mid_mtime: got %h want %h", rd, x_rd); end
  endtask

  task automatic test_random();
    logic [15:0] addrs [6];
    logic [15:0] a;
    logic        we;
    addrs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h0000};
    for (int i = 0; i < 60; i++) begin
      a = addrs[$urandom_range(0, 4)] | 16'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) a = 16'($urandom);
      we = 1'($urandom_range(0, 1));
      bus(we, a, $urandom, 4'($urandom), rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
      n_cmp += 5;
      if (ack !== x_ack || err !== x_err) begin
        n_bad++; $display("FAIL rnd_resp @%h: got ack=%b err=%b want ack=%b err=%b", a, ack, err, x_ack, x_err);
      end
      if (!we && rd !== x_rd) begin n_bad++; $display("FAIL rnd_read @%h: got %h want %h", a, rd, x_rd); end
      if (ms0 !== x_ms0) begin n_bad++; $display("FAIL rnd_msip: got %b want %b", ms0, x_ms0); end
      if (mt0 !== x_mt0) begin n_bad++; $display("FAIL rnd_mtip_ack: got %b want %b", mt0, x_mt0); end
      if (mt1 !== x_mt1) begin n_bad++; $display("FAIL rnd_mtip_next: got %b want %b", mt1, x_mt1); end
    end
  endtask

`ifdef CLINT_PRESCALE_EN
  task automatic test_prescale();
    logic [31:0] first;
    do_reset();
    bus(0, 16'hBFF8, 32'h0, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    first = rd;
    repeat (98) @(posedge clk);
    #1;
    bus(0, 16'hBFF8, 32'h0, 4'hF, rd, ack, err, mt0, ms0, mt1, x_rd, x_ack, x_err, x_mt0, x_ms0, x_mt1);
    n_cmp += 2;
    if (rd - first !== 32'd10) begin n_bad++; $display("FAIL prescale_rate: got %0d want 10", rd - first); end
    if (rd !== x_rd) begin n_bad++; $display("FAIL prescale_value: got %h want %h", rd, x_rd); end
  endtask
`endif

  initial begin
    test_reset();
    test_timer();
    test_msip();
    test_bytes();
    test_wrap();
    test_back_to_back();
    test_rst_mid();
    test_random();
`ifdef CLINT_PRESCALE_EN
    test_prescale();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
